// File: rtl/sample_iid_trits.sv
// Streams one ternary polynomial: each accepted 16-bit random word becomes a
// pair of coefficients (byte mod 3), followed by a zero padding beat tagged last.
`timescale 1ns/1ps
module sample_iid_trits #(
   parameter int N     = 701,
   parameter int PAIRS = (N - 1) / 2
) (
   input  logic        clk,
   input  logic        ovr_rst1,
   input  logic        start,
   input  logic [15:0] rnd,
   input  logic        rnd_valid,
   output logic        rnd_ready,
   output logic [3:0]  trits,
   output logic [8:0]  trit_idx,
   output logic        trit_valid,
   input  logic        trit_ready,
   output logic        trit_last,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_LAST,
      S_DRAIN
   } state_t;

   localparam logic [8:0] PAIRS_M1 = 9'(PAIRS - 1);
   localparam logic [8:0] LAST_IDX = 9'(PAIRS);

   state_t     state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic [3:0] trits_q, trits_d;
   logic [8:0] idx_q, idx_d;
   logic       last_q, last_d;
   logic       tv_q, tv_d;
   logic       done_q, done_d;
   logic       out_free;
   logic       accept;
   logic       out_xfer;

   // 4 = 1 (mod 3), so the sum of base-4 digits keeps the residue; fold twice.
   function automatic logic [1:0] mod3(input logic [7:0] b);
      logic [3:0] s;
      logic [2:0] t;
      s = 4'(b[7:6]) + 4'(b[5:4]) + 4'(b[3:2]) + 4'(b[1:0]);
      t = 3'(s[3:2]) + 3'(s[1:0]);
      case (t)
         3'd0, 3'd3, 3'd6: return 2'd0;
         3'd1, 3'd4:       return 2'd1;
         default:          return 2'd2;
      endcase
   endfunction

   assign out_free  = !tv_q || trit_ready;
   assign out_xfer  = tv_q && trit_ready;
   assign rnd_ready = (state_q == S_RUN) && out_free;
   assign accept    = rnd_ready && rnd_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trits_d = trits_q;
      idx_d   = idx_q;
      last_d  = last_q;
      tv_d    = tv_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               trits_d = {mod3(rnd[15:8]), mod3(rnd[7:0])};
               idx_d   = cnt_q;
               last_d  = 1'b0;
               tv_d    = 1'b1;
               cnt_d   = cnt_q + 9'd1;
               if (cnt_q == PAIRS_M1) state_d = S_LAST;
            end else if (out_xfer) begin
               tv_d = 1'b0;
            end
         end
         S_LAST: begin
            // Padding beat carries coefficients N-1 and N, both zero.
            if (out_free) begin
               trits_d = 4'b0000;
               idx_d   = LAST_IDX;
               last_d  = 1'b1;
               tv_d    = 1'b1;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_xfer) begin
               tv_d    = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge ovr_rst1) begin
      if (ovr_rst1) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         trits_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         tv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trits_q <= trits_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         tv_q    <= tv_d;
         done_q  <= done_d;
      end
   end

   assign trits      = trits_q;
   assign trit_idx   = idx_q;
   assign trit_last  = last_q;
   assign trit_valid = tv_q;
   assign done       = done_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sample_iid_trits.sv
// Bench for sample_iid_trits: scoreboard of expected beats built from accepted
// words, compared against observed output transfers.
`timescale 1ns/1ps
module tb_sample_iid_trits;

   localparam int PAIRS = 350;

   logic        clk = 1'b0;
   logic        ovr_rst1 = 1'b1;
   logic        start = 1'b0;
   logic [15:0] rnd = 16'h0;
   logic        rnd_valid = 1'b0;
   logic        rnd_ready;
   logic [3:0]  trits;
   logic [8:0]  trit_idx;
   logic        trit_valid;
   logic        trit_ready = 1'b1;
   logic        trit_last;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail = 0;

   // {idx, last, trits}
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];
   int m_cnt = 0;
   int acc_cnt = 0;
   int beat_cnt = 0;
   int done_cnt = 0;

   sample_iid_trits #(.N(701), .PAIRS(PAIRS)) dut (
      .clk        (clk),
      .ovr_rst1   (ovr_rst1),
      .start      (start),
      .rnd        (rnd),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .trits      (trits),
      .trit_idx   (trit_idx),
      .trit_valid (trit_valid),
      .trit_ready (trit_ready),
      .trit_last  (trit_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Handshakes are stable mid-cycle; what is seen here transfers on the next edge.
   always @(negedge clk) begin
      if (ovr_rst1) begin
         m_cnt <= 0;
      end else begin
         if (start && !busy) m_cnt <= 0;
         if (rnd_valid && rnd_ready) begin
            exp_q.push_back({9'(m_cnt), 1'b0, 2'(int'(rnd[15:8]) % 3), 2'(int'(rnd[7:0]) % 3)});
            if (m_cnt == PAIRS - 1) exp_q.push_back({9'(PAIRS), 1'b1, 4'b0000});
            m_cnt   <= m_cnt + 1;
            acc_cnt <= acc_cnt + 1;
         end
         if (trit_valid && trit_ready) begin
            obs_q.push_back({trit_idx, trit_last, trits});
            beat_cnt <= beat_cnt + 1;
         end
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drive_word(input logic [15:0] w, output bit got);
      got = 1'b0;
      rnd = w;
      rnd_valid = 1'b1;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         if (rnd_ready) got = 1'b1;
         @(posedge clk); #1;
      end
      rnd_valid = 1'b0;
   endtask

   task automatic finish_run(input int vpct, input int rpct, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         rnd        = 16'($urandom);
         rnd_valid  = (int'($urandom_range(99)) < vpct);
         trit_ready = (int'($urandom_range(99)) < rpct);
         @(posedge clk); #1;
      end
      rnd_valid  = 1'b0;
      trit_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      ovr_rst1 = 1'b1;
      rnd_valid = 1'b1;
      rnd = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({trit_valid, trits, trit_idx, trit_last, busy, done, rnd_ready} !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {trit_valid, trits, trit_idx, trit_last, busy, done, rnd_ready});
      end
      ovr_rst1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({rnd_ready, busy, trit_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy/busy/vld=%b want 000", {rnd_ready, busy, trit_valid});
         end
      end
      rnd_valid = 1'b0;
   endtask

   task automatic test_first_beat;
      bit ok;
      trit_ready = 1'b1;
      rnd = 16'h02FE;
      rnd_valid = 1'b1;
      pulse_start();
      n_checks++;
      if (trit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL first_latency: trit_valid=%b want 0 before first accept", trit_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({trit_valid, trits, trit_idx} !== {1'b1, 4'b1010, 9'd0}) begin
         n_fail++;
         $display("FAIL first_beat: got v=%b t=%b i=%0d want v=1 t=1010 i=0", trit_valid, trits, trit_idx);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({trit_valid, trits, trit_idx} !== {1'b1, 4'b1010, 9'd1}) begin
         n_fail++;
         $display("FAIL second_beat: got v=%b t=%b i=%0d want v=1 t=1010 i=1", trit_valid, trits, trit_idx);
      end
      finish_run(80, 80, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL first_run_end: busy still %b after cycle budget, want 0", busy);
      end
   endtask

   task automatic test_patterns;
      bit got, ok;
      trit_ready = 1'b1;
      pulse_start();
      drive_word(16'h8001, got);
      n_checks++;
      if ({got, trit_valid, trits, trit_idx} !== {2'b11, 4'b1001, 9'd0}) begin
         n_fail++;
         $display("FAIL pattern_8001: got acc=%b v=%b t=%b i=%0d want 1 1 1001 0", got, trit_valid, trits, trit_idx);
      end
      drive_word(16'hFF00, got);
      n_checks++;
      if ({got, trit_valid, trits, trit_idx} !== {2'b11, 4'b0000, 9'd1}) begin
         n_fail++;
         $display("FAIL pattern_ff00: got acc=%b v=%b t=%b i=%0d want 1 1 0000 1", got, trit_valid, trits, trit_idx);
      end
      finish_run(90, 90, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pattern_run_end: busy %b want 0", busy);
      end
   endtask

   task automatic test_backpressure;
      bit got, ok;
      int e0, o0;
      e0 = exp_q.size();
      o0 = obs_q.size();
      trit_ready = 1'b0;
      pulse_start();
      drive_word(16'h1234, got);
      rnd = 16'h5678;
      rnd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({got, rnd_ready, trit_valid, trits, trit_idx} !== {3'b101, 4'b0001, 9'd0}) begin
            n_fail++;
            $display("FAIL stall_hold: got acc=%b rdy=%b v=%b t=%b i=%0d want 1 0 1 0001 0",
                     got, rnd_ready, trit_valid, trits, trit_idx);
         end
      end
      @(posedge clk); #1;
      trit_ready = 1'b1;
      @(posedge clk); #1;
      rnd_valid = 1'b0;
      n_checks++;
      if ({trit_valid, trits, trit_idx} !== {1'b1, 4'b1000, 9'd1}) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b t=%b i=%0d want 1 1000 1", trit_valid, trits, trit_idx);
      end
      finish_run(70, 60, ok);
      n_checks++;
      if (!ok || (exp_q.size() - e0) !== (obs_q.size() - o0)) begin
         n_fail++;
         $display("FAIL bp_count: ended=%b beats=%0d want %0d", ok, obs_q.size() - o0, exp_q.size() - e0);
      end
      for (int i = 0; i < obs_q.size() - o0 && e0 + i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[o0 + i] !== exp_q[e0 + i]) begin
            n_fail++;
            $display("FAIL bp_beat %0d: got %h want %h", i, obs_q[o0 + i], exp_q[e0 + i]);
         end
      end
   endtask

   task automatic test_full_run;
      bit ok;
      int e0, o0, a0, b0, d0;
      e0 = exp_q.size();
      o0 = obs_q.size();
      a0 = acc_cnt;
      b0 = beat_cnt;
      d0 = done_cnt;
      pulse_start();
      finish_run(60, 60, ok);
      n_checks++;
      if ({ok, 32'(acc_cnt - a0), 32'(beat_cnt - b0), 32'(done_cnt - d0)} !==
          {1'b1, 32'(PAIRS), 32'(PAIRS + 1), 32'd1}) begin
         n_fail++;
         $display("FAIL full_counts: got ended=%b words=%0d beats=%0d done=%0d want 1 %0d %0d 1",
                  ok, acc_cnt - a0, beat_cnt - b0, done_cnt - d0, PAIRS, PAIRS + 1);
      end
      n_checks++;
      if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {9'(PAIRS), 1'b1, 4'b0000}) begin
         n_fail++;
         $display("FAIL full_last_beat: got %h want %h",
                  (obs_q.size() == 0) ? 14'h0 : obs_q[obs_q.size() - 1], {9'(PAIRS), 1'b1, 4'b0000});
      end
      for (int i = 0; i < obs_q.size() - o0 && e0 + i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[o0 + i] !== exp_q[e0 + i]) begin
            n_fail++;
            $display("FAIL full_beat %0d: got %h want %h", i, obs_q[o0 + i], exp_q[e0 + i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      bit got, ok;
      int a0, b0, d0;
      trit_ready = 1'b1;
      pulse_start();
      a0 = acc_cnt;
      for (int c = 0; c < 2000; c++) begin
         if (acc_cnt - a0 >= 100) break;
         rnd = 16'($urandom);
         rnd_valid = (int'($urandom_range(99)) < 80);
         @(posedge clk); #1;
      end
      rnd_valid = 1'b1;
      #2;
      ovr_rst1 = 1'b1;
      #1;
      n_checks++;
      if ({trit_valid, trits, trit_idx, trit_last, busy, done, rnd_ready} !== 18'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got %b want all zero (pairs accepted %0d)",
                  {trit_valid, trits, trit_idx, trit_last, busy, done, rnd_ready}, acc_cnt - a0);
      end
      @(posedge clk);
      @(posedge clk); #1;
      ovr_rst1 = 1'b0;
      b0 = beat_cnt;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({trit_valid, busy, done, rnd_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_quiet: got v/busy/done/rdy=%b want 0000", {trit_valid, busy, done, rnd_ready});
         end
      end
      n_checks++;
      if ({32'(beat_cnt - b0), 32'(done_cnt - d0)} !== 64'd0) begin
         n_fail++;
         $display("FAIL midrst_no_beat: beats=%0d done=%0d want 0 0", beat_cnt - b0, done_cnt - d0);
      end
      rnd_valid = 1'b0;
      pulse_start();
      drive_word(16'h0102, got);
      n_checks++;
      if ({got, trit_valid, trits, trit_idx} !== {2'b11, 4'b0110, 9'd0}) begin
         n_fail++;
         $display("FAIL midrst_restart: got acc=%b v=%b t=%b i=%0d want 1 1 0110 0", got, trit_valid, trits, trit_idx);
      end
      finish_run(80, 80, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL midrst_run_end: busy %b want 0", busy);
      end
   endtask

   task automatic test_ignored;
      bit got, found;
      int e0, o0, d0;
      e0 = exp_q.size();
      o0 = obs_q.size();
      d0 = done_cnt;
      found = 1'b0;
      trit_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 5; i++) drive_word(16'($urandom), got);
      pulse_start();
      for (int c = 0; c < 3000; c++) begin
         if (trit_valid && trit_last) begin
            found = 1'b1;
            break;
         end
         rnd = 16'($urandom);
         rnd_valid  = (int'($urandom_range(99)) < 80);
         trit_ready = (int'($urandom_range(99)) < 70);
         @(posedge clk); #1;
      end
      trit_ready = 1'b0;
      rnd_valid = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if ({found, busy, trit_valid, trit_last} !== 4'b1111) begin
         n_fail++;
         $display("FAIL drain_hold: got found/busy/v/last=%b want 1111", {found, busy, trit_valid, trit_last});
      end
      @(posedge clk); #1;
      trit_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL drain_done: got done/busy=%b want 10", {done, busy});
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({rnd_ready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ignore: got rdy/busy/done=%b want 000", {rnd_ready, busy, done});
         end
      end
      rnd_valid = 1'b0;
      n_checks++;
      if (done_cnt - d0 !== 1 || (exp_q.size() - e0) !== (obs_q.size() - o0)) begin
         n_fail++;
         $display("FAIL ign_count: got done=%0d beats=%0d want 1 %0d", done_cnt - d0, obs_q.size() - o0, exp_q.size() - e0);
      end
      for (int i = 0; i < obs_q.size() - o0 && e0 + i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[o0 + i] !== exp_q[e0 + i]) begin
            n_fail++;
            $display("FAIL ign_beat %0d: got %h want %h", i, obs_q[o0 + i], exp_q[e0 + i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_beat();
      test_patterns();
      test_backpressure();
      test_full_run();
      test_reset_mid();
      test_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_iid_trits.md
SAMPLE_IID_TRITS -- requirements
Module: sample_iid_trits

Interface
REQ-001 The block SHALL have parameter N, default 701, meaning the polynomial length in ternary coefficients (odd, 3..1023).
REQ-002 The block SHALL have parameter PAIRS, default (N-1)/2 = 350, meaning the number of random-derived coefficient pairs.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-004 The block SHALL have port ovr_rst1, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, single-cycle request to begin sampling one polynomial.
REQ-006 The block SHALL have port rnd, input, 16 bits, random word: byte rnd[15:8] gives the odd coefficient, byte rnd[7:0] gives the even coefficient.
REQ-007 The block SHALL have ports rnd_valid (input, 1) and rnd_ready (output, 1); a word transfers on a clk edge with both high.
REQ-008 The block SHALL have port trits, output, 4 bits, {coef[2i+1], coef[2i]}, each encoded 00=0, 01=1, 10=2 (i.e. -1); 11 never driven.
REQ-009 The block SHALL have port trit_idx, output, 9 bits, the pair index i of the current beat.
REQ-010 The block SHALL have ports trit_valid (output, 1) and trit_ready (input, 1); a beat transfers on a clk edge with both high.
REQ-011 The block SHALL have port trit_last, output, 1 bit, high with the final beat (i = PAIRS).
REQ-012 The block SHALL have port busy, output, 1 bit, high in states RUN, LAST and DRAIN.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the final beat transfers.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, LAST, DRAIN.
REQ-015 IDLE SHALL go to RUN on start=1 and clear the pair counter; start in any other state SHALL be ignored.
REQ-016 In RUN, rnd_ready SHALL be (!trit_valid || trit_ready); in all other states it SHALL be 0.
REQ-017 Each coefficient SHALL equal its byte value mod 3 (range 0..255 -> 0..2), computed combinationally on accept.
REQ-018 An accepted word SHALL appear registered on trits with trit_valid=1 on the next cycle (latency 1); trit_idx SHALL equal the counter value at accept time.
REQ-019 The output register SHALL hold trits, trit_idx and trit_last stable while trit_valid=1 and trit_ready=0.
REQ-020 Accept and output transfer on the same edge SHALL load the new beat with no bubble (full throughput, 1 pair per cycle).
REQ-021 The counter SHALL increment per accepted word; the accept of pair PAIRS-1 SHALL move RUN to LAST.
REQ-022 In LAST, when the output register is free or transferring, the block SHALL load trits=4'b0000, trit_idx=PAIRS, trit_last=1 without consuming rnd, then move to DRAIN.
REQ-023 In DRAIN, the transfer of the trit_last beat SHALL clear trit_valid, pulse done on the following cycle, and return to IDLE.
REQ-024 rnd_valid in IDLE or DRAIN SHALL be ignored; no word SHALL be consumed.
REQ-025 Exactly PAIRS words and PAIRS+1 beats SHALL be exchanged per polynomial; coefficient N-1 and padding coefficient N SHALL both be 0.

Reset
REQ-026 While ovr_rst1=1: state=IDLE, counter=0, trit_valid=0, trits=0, trit_idx=0, trit_last=0, busy=0, done=0, rnd_ready=0.
REQ-027 Reset asserted mid-polynomial SHALL abort immediately; no partial beat or done pulse SHALL follow deassertion.
REQ-028 After reset deassertion the block SHALL wait in IDLE for start.

Verification
REQ-029 Reset, start, rnd=16'h02FE held valid, trit_ready=1 -> first beat one cycle after first accept: trits=4'b1010, idx=0.
REQ-030 rnd=16'h8001, then 16'hFF00 -> beats trits=4'b1001, then 4'b0000; idx increments 0, 1.
REQ-031 trit_ready=0 for 5 cycles with a beat pending -> rnd_ready=0 and trits/idx unchanged; on release, no word is lost or duplicated.
REQ-032 Full run with random rnd and random valid/ready gaps -> 350 words consumed, 351 beats; last beat idx=350, trits=0, trit_last=1; done pulses once; every coefficient equals the reference byte mod 3.
REQ-033 ovr_rst1 pulsed at pair 100 -> all outputs return to reset values; a fresh start produces idx=0 first.
REQ-034 start pulsed during RUN and DRAIN -> ignored; rnd_valid in IDLE -> rnd_ready stays 0.
